// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU.
// Owns the architectural HI/LO registers and accepts MTHI/MTLO writes while idle.
// Every operation takes 33 cycles: 32 radix-2 steps, then one sign-fix/load cycle.
module mult_div_unit #(
  parameter int unsigned WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [WORD_W-1:0] wdat,
  output logic              busy,
  output logic              done,
  output logic              dbz,
  output logic [WORD_W-1:0] hi,
  output logic [WORD_W-1:0] lo
);

  localparam int unsigned CntW = $clog2(WORD_W);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                is_div_q, is_div_d;
  logic                neg_res_q, neg_res_d;  // product/quotient negated in FIX
  logic                neg_rem_q, neg_rem_d;  // remainder follows the dividend sign
  logic                zero_div_q, zero_div_d;
  logic [WORD_W-1:0]   a_raw_q, a_raw_d;      // original dividend, returned on divide by zero
  logic [WORD_W-1:0]   opnd_q, opnd_d;        // multiplicand magnitude or divisor magnitude
  logic [2*WORD_W-1:0] acc_q, acc_d;          // {upper, lower}: product, or {remainder, quotient}
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                dbz_q, dbz_d;
  logic [WORD_W-1:0]   hi_q, hi_d;
  logic [WORD_W-1:0]   lo_q, lo_d;

  logic                a_neg, b_neg;
  logic [WORD_W-1:0]   a_mag, b_mag;
  logic [WORD_W:0]     mul_sum;
  logic [2*WORD_W-1:0] mul_next;
  logic [WORD_W:0]     div_shift;
  logic [WORD_W+1:0]   div_diff;
  logic [2*WORD_W-1:0] div_next;
  logic [2*WORD_W-1:0] prod_fix;
  logic [WORD_W-1:0]   quo, rem;

  // Operand magnitudes; op[0]=0 selects the signed variants. abs(most negative) wraps to itself.
  always_comb begin
    a_neg = ~op[0] & A[WORD_W-1];
    b_neg = ~op[0] & B[WORD_W-1];
    a_mag = a_neg ? -A : A;
    b_mag = b_neg ? -B : B;
  end

  // Single radix-2 step for each operation, plus the FIX-stage sign correction.
  always_comb begin
    // Shift-add: add the multiplicand into the upper half when the low bit is set, shift right.
    mul_sum   = {1'b0, acc_q[2*WORD_W-1:WORD_W]}
              + (acc_q[0] ? {1'b0, opnd_q} : {(WORD_W + 1){1'b0}});
    mul_next  = {mul_sum, acc_q[WORD_W-1:1]};
    // Restoring divide: shift the next dividend bit into the 33-bit partial remainder.
    div_shift = acc_q[2*WORD_W-1:WORD_W-1];
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    if (div_diff[WORD_W+1]) begin
      div_next = {div_shift[WORD_W-1:0], acc_q[WORD_W-2:0], 1'b0};
    end else begin
      div_next = {div_diff[WORD_W-1:0], acc_q[WORD_W-2:0], 1'b1};
    end
    prod_fix  = neg_res_q ? -acc_q : acc_q;
    quo       = acc_q[WORD_W-1:0];
    rem       = acc_q[2*WORD_W-1:WORD_W];
  end

  // Next-state logic: issue, iterate, fix up and load HI/LO; MTHI/MTLO only when idle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    zero_div_d = zero_div_q;
    a_raw_d    = a_raw_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dbz_d      = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StCalc;
          busy_d     = 1'b1;
          cnt_d      = '0;
          is_div_d   = op[1];
          neg_res_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          zero_div_d = op[1] & (B == '0);
          a_raw_d    = A;
          opnd_d     = op[1] ? b_mag : a_mag;
          acc_d      = {{WORD_W{1'b0}}, (op[1] ? a_mag : b_mag)};
        end else begin
          if (hi_we) hi_d = wdat;
          if (lo_we) lo_d = wdat;
        end
      end
      StCalc: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WORD_W - 1)) state_d = StFix;
      end
      StFix: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dbz_d   = zero_div_q;
        if (zero_div_q) begin
          lo_d = {WORD_W{1'b1}};
          hi_d = a_raw_q;
        end else if (is_div_q) begin
          lo_d = neg_res_q ? -quo : quo;
          hi_d = neg_rem_q ? -rem : rem;
        end else begin
          hi_d = prod_fix[2*WORD_W-1:WORD_W];
          lo_d = prod_fix[WORD_W-1:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_div_q <= 1'b0;
      a_raw_q    <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      zero_div_q <= zero_div_d;
      a_raw_q    <= a_raw_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dbz  = dbz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
